// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Posted-store FIFO sitting between the MEM-stage pipeline register and the
//   data memory. Stores (sb/sh/sw) are queued and retired in program order
//   whenever the shared memory address port is not needed by a load. A load
//   always wins the port unless its word address matches a buffered store. In
//   that case the load is held (ld_stall) while the buffer drains.
//   Misaligned stores and unknown funct3 values are rejected and reported with
//   a one-cycle registered pulse. A fence/CSR drain request blocks new stores
//   and all loads until the buffer is empty.
//
// Optional feature (macro STORE_FWD_EN):
//   When the newest matching entry is a sw, the load is served from that word.
//   This raises fwd_valid/fwd_data instead of stalling. The port keeps
//   draining the head entry meanwhile. Without the macro the fwd_* ports do not
//   exist and every conflict stalls.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   st_valid/st_addr/st_data/st_funct3 -> st_ready   store request / accept
//   ld_valid/ld_addr/ld_funct3    -> ld_stall        load request / hold
//   drain_req                     fence/CSR drain request
//   empty                         buffer holds no entries
//   misaligned_st                 registered pulse for a rejected store
//   mem_wr_en/mem_addr/mem_wr_data/mem_funct3       data-memory port
//   fwd_valid/fwd_data            (STORE_FWD_EN only) forwarded load data
//
// Limits: MEM_SIZE and DEPTH must be powers of two. The conflict compare uses
// word-address bits [2 +: log2(MEM_SIZE)], which is the word address modulo
// MEM_SIZE.
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int MEM_SIZE   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            st_funct3,
  output logic                  st_ready,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  output logic                  ld_stall,
  input  logic                  drain_req,
  output logic                  empty,
  output logic                  misaligned_st,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [2:0]            mem_funct3
`ifdef STORE_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = $clog2(MEM_SIZE);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Entry storage; only the valid bits need reset.
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [2:0]            f3_q   [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          mis_q, mis_d;

  logic          empty_s;
  logic          aligned_s;
  logic          push_s;
  logic          pop_s;
  logic          hit_s;
  logic          conflict_s;
  logic          drain_force_s;
  logic          load_grant_s;
  logic          fwd_hit_s;
  logic [PW-1:0] scan_idx_s;

`ifdef STORE_FWD_EN
  logic                  newest_sw_s;
  logic [DATA_WIDTH-1:0] newest_data_s;
`endif

  // sb: any address; sh: halfword aligned; sw: word aligned; anything else is rejected.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (a[0] == 1'b0);
      3'b010:  ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef STORE_FWD_EN
  // Load funct3 values that can be served from a buffered word.
  function automatic logic fwd_f3_ok(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Select the byte/halfword addressed by the load, then sign- or zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [DATA_WIDTH-1:0] w,
                                                         input logic [1:0] off,
                                                         input logic [2:0] f3);
    logic [DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] r;
    s = w >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{(DATA_WIDTH-8){s[7]}}, s[7:0]};
      3'b001:  r = {{(DATA_WIDTH-16){s[15]}}, s[15:0]};
      3'b010:  r = s;
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction
`endif

  // Compare the load word address against every valid entry.
  // The scan runs oldest to newest, so the last match seen is the newest store.
  always_comb begin
    hit_s      = 1'b0;
    scan_idx_s = rd_ptr_q;
`ifdef STORE_FWD_EN
    newest_sw_s   = 1'b0;
    newest_data_s = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = rd_ptr_q + PW'(i);
      if (valid_q[scan_idx_s] && (addr_q[scan_idx_s][2 +: MW] == ld_addr[2 +: MW])) begin
        hit_s = 1'b1;
`ifdef STORE_FWD_EN
        newest_sw_s   = (f3_q[scan_idx_s] == 3'b010);
        newest_data_s = data_q[scan_idx_s];
`endif
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Port arbitration: loads first, the head store drains whenever the port is not granted.
  always_comb begin
    empty_s       = (count_q == '0);
    aligned_s     = is_aligned(st_funct3, st_addr[1:0]);
    st_ready      = (count_q < FULL_COUNT) && !drain_req;
    push_s        = st_valid && st_ready && aligned_s;
    conflict_s    = ld_valid && hit_s;
    drain_force_s = drain_req && !empty_s;
`ifdef STORE_FWD_EN
    fwd_hit_s     = conflict_s && newest_sw_s && fwd_f3_ok(ld_funct3) && !drain_force_s;
    fwd_valid     = fwd_hit_s;
    if (fwd_hit_s) begin
      fwd_data = extract_load(newest_data_s, ld_addr[1:0], ld_funct3);
    end else begin
      fwd_data = '0;
    end
`else
    fwd_hit_s     = 1'b0;
`endif
    load_grant_s  = ld_valid && !conflict_s && !drain_force_s;
    pop_s         = !empty_s && !load_grant_s;
    ld_stall      = drain_force_s || (conflict_s && !fwd_hit_s);
    empty         = empty_s;
    mem_wr_en     = pop_s;
    mem_wr_data   = data_q[rd_ptr_q];
    if (pop_s) begin
      mem_addr   = addr_q[rd_ptr_q];
      mem_funct3 = f3_q[rd_ptr_q];
    end else begin
      mem_addr   = ld_addr;
      mem_funct3 = ld_funct3;
    end
  end

  // Pointer, occupancy and valid-bit next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    mis_d    = st_valid && !aligned_s;
    if (push_s) begin
      wr_ptr_d          = wr_ptr_q + PW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d          = rd_ptr_q + PW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards any pending entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
    end
  end

  // Entry payload capture on push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
      f3_q[wr_ptr_q]   <= st_funct3;
    end
  end

  assign misaligned_st = mis_q;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed, self-checking bench for store_buffer. Every accepted store pushes
//   its expected memory write into a scoreboard queue. A negedge monitor pops
//   the queue and compares it whenever the DUT writes memory. The initial block
//   drives a linear sequence of directed steps and checks port arbitration,
//   stalls, misalignment pulses, drain requests and reset. Define STORE_FWD_EN
//   to also check store-to-load forwarding.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_stall;
  logic        drain_req;
  logic        empty;
  logic        misaligned_st;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [2:0]  mem_funct3;
`ifdef STORE_FWD_EN
  logic        fwd_valid;
  logic [31:0] fwd_data;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .MEM_SIZE(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_funct3    (st_funct3),
    .st_ready     (st_ready),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_funct3    (ld_funct3),
    .ld_stall     (ld_stall),
    .drain_req    (drain_req),
    .empty        (empty),
    .misaligned_st(misaligned_st),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_funct3   (mem_funct3)
`ifdef STORE_FWD_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_data     (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input bit accept);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f;
    if (accept) exp_q.push_back('{addr: a, data: d, f3: f});
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f);
    ld_valid  = 1'b1;
    ld_addr   = a;
    ld_funct3 = f;
  endtask

  // Scoreboard: each memory write must match the oldest expected store.
  always @(negedge clk) begin
    if (!rst && mem_wr_en === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL wr_unexpected: observed write addr %h, expected no write", mem_addr);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wr_data, e.data);
        chk("wr_f3", {29'd0, mem_funct3}, {29'd0, e.f3});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_st_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_ld_stall", ld_stall, 0);
    chk("rst_misaligned", misaligned_st, 0);
    chk("rst_wr_en", mem_wr_en, 0);

    // 1: single sw, drained the next cycle.
    cyc(); rst = 1'b0; store(32'h10, 32'hDEADBEEF, 3'b010, 1); #1;
    chk("t1_ready", st_ready, 1);
    chk("t1_no_wr_yet", mem_wr_en, 0);
    cyc(); st_valid = 1'b0; #1;
    chk("t1_wr_en", mem_wr_en, 1);
    chk("t1_addr", mem_addr, 32'h10);
    cyc(); #1;
    chk("t1_empty", empty, 1);
    chk("t1_idle", mem_wr_en, 0);

    // 2: fill while a non-conflicting load holds the port, then drain in order.
    for (int i = 0; i < 4; i++) begin
      cyc(); load(32'h80, 3'b010); store(32'(i * 4), 32'hA0 + 32'(i), 3'b010, 1); #1;
      chk("t2_ready", st_ready, 1);
      chk("t2_no_wr", mem_wr_en, 0);
      chk("t2_ld_stall", ld_stall, 0);
      chk("t2_ld_addr", mem_addr, 32'h80);
    end
    cyc(); store(32'h3C, 32'hFF, 3'b010, 0); #1;
    chk("t2_full_ready", st_ready, 0);
    chk("t2_full_no_wr", mem_wr_en, 0);
    cyc(); st_valid = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #1;
      chk("t2_drain_en", mem_wr_en, 1);
      chk("t2_drain_addr", mem_addr, 32'(i * 4));
    end
    cyc(); #1;
    chk("t2_empty", empty, 1);

    // 3: sb 0x21 then lbu 0x20 conflicts; an aliased lw 0x120 conflicts with sh 0x20.
    cyc(); store(32'h21, 32'hAB, 3'b000, 1); #1;
    chk("t3_no_stall", ld_stall, 0);
    cyc(); st_valid = 1'b0; load(32'h20, 3'b100); #1;
    chk("t3_stall", ld_stall, 1);
    chk("t3_drain_en", mem_wr_en, 1);
    chk("t3_drain_addr", mem_addr, 32'h21);
    chk("t3_drain_f3", {29'd0, mem_funct3}, 32'd0);
    cyc(); #1;
    chk("t3_granted", ld_stall, 0);
    chk("t3_grant_wr", mem_wr_en, 0);
    chk("t3_grant_addr", mem_addr, 32'h20);
    chk("t3_grant_f3", {29'd0, mem_funct3}, 32'd4);
    cyc(); store(32'h20, 32'h1234, 3'b001, 1); load(32'h120, 3'b010); #1;
    chk("t3_not_visible", ld_stall, 0);
    chk("t3_alias_addr", mem_addr, 32'h120);
    cyc(); st_valid = 1'b0; #1;
    chk("t3_alias_stall", ld_stall, 1);
    chk("t3_alias_drain", mem_addr, 32'h20);
    cyc(); #1;
    chk("t3_alias_clear", ld_stall, 0);
    chk("t3_alias_empty", empty, 1);

    // 4: misaligned sh/sw and unknown funct3 give a registered pulse and are not enqueued.
    cyc(); ld_valid = 1'b0; store(32'h13, 32'h1, 3'b001, 0); #1;
    chk("t4_pulse_late", misaligned_st, 0);
    cyc(); store(32'h12, 32'h2, 3'b010, 0); #1;
    chk("t4_sh_pulse", misaligned_st, 1);
    chk("t4_sh_empty", empty, 1);
    cyc(); store(32'h0, 32'h3, 3'b011, 0); #1;
    chk("t4_sw_pulse", misaligned_st, 1);
    chk("t4_sw_empty", empty, 1);
    cyc(); st_valid = 1'b0; #1;
    chk("t4_f3_pulse", misaligned_st, 1);
    chk("t4_f3_no_wr", mem_wr_en, 0);
    cyc(); #1;
    chk("t4_pulse_end", misaligned_st, 0);

    // 5: drain_req with three entries blocks loads and stores until empty.
    for (int i = 0; i < 3; i++) begin
      cyc(); load(32'h80, 3'b010); store(32'h30 + 32'(i * 4), 32'hC0 + 32'(i), 3'b010, 1); #1;
    end
    cyc(); st_valid = 1'b0; drain_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      #1;
      chk("t5_stall", ld_stall, 1);
      chk("t5_ready", st_ready, 0);
      chk("t5_drain", mem_wr_en, 1);
      chk("t5_drain_addr", mem_addr, 32'h30 + 32'(i * 4));
    end
    cyc(); #1;
    chk("t5_empty", empty, 1);
    chk("t5_unstall", ld_stall, 0);
    chk("t5_ready_held", st_ready, 0);
    cyc(); drain_req = 1'b0; #1;
    chk("t5_ready_back", st_ready, 1);
    chk("t5_idle", mem_wr_en, 0);

    // 6: sw then lb/lhu of the same word: forwarded when enabled, otherwise stalled.
    cyc(); load(32'h80, 3'b010); store(32'h40, 32'h80FF1234, 3'b010, 1); #1;
    cyc(); st_valid = 1'b0; load(32'h43, 3'b000); #1;
`ifdef STORE_FWD_EN
    chk("t6_fwd_valid", fwd_valid, 1);
    chk("t6_fwd_lb", fwd_data, 32'hFFFFFF80);
    chk("t6_fwd_nostall", ld_stall, 0);
`else
    chk("t6_stall", ld_stall, 1);
`endif
    chk("t6_drain", mem_wr_en, 1);
    chk("t6_drain_addr", mem_addr, 32'h40);
    cyc(); load(32'h80, 3'b010); store(32'h44, 32'h80FF1234, 3'b010, 1); #1;
    cyc(); st_valid = 1'b0; load(32'h46, 3'b101); #1;
`ifdef STORE_FWD_EN
    chk("t6_fwd_lhu", fwd_data, 32'h000080FF);
    chk("t6_lhu_nostall", ld_stall, 0);
`else
    chk("t6_lhu_stall", ld_stall, 1);
`endif
    cyc(); load(32'h80, 3'b010); store(32'h48, 32'h11223344, 3'b010, 1); #1;
    cyc(); store(32'h48, 32'h55, 3'b000, 1); #1;
    cyc(); st_valid = 1'b0; load(32'h48, 3'b100); #1;
    chk("t6_sb_newest_stall", ld_stall, 1);
    chk("t6_sb_drain_addr", mem_addr, 32'h48);
`ifdef STORE_FWD_EN
    chk("t6_sb_no_fwd", fwd_valid, 0);
`endif
    cyc(); #1;
    chk("t6_sb_still_stall", ld_stall, 1);
    cyc(); ld_valid = 1'b0; #1;
    chk("t6_empty", empty, 1);

    // Reset in the middle of a drain discards the remaining entries.
    for (int i = 0; i < 3; i++) begin
      cyc(); load(32'h80, 3'b010); store(32'h50 + 32'(i * 4), 32'hE0 + 32'(i), 3'b010, i == 0);
      #1;
    end
    cyc(); st_valid = 1'b0; ld_valid = 1'b0; #1;
    chk("rst_mid_drain", mem_addr, 32'h50);
    cyc(); rst = 1'b1; #1;
    cyc(); rst = 1'b0; #1;
    chk("rst_mid_wr_en", mem_wr_en, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_ready", st_ready, 1);

    // Every expected write must have been observed within a bounded window.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
